// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter that retires one input bit per clock.
// Optional macro BCD_LEADING_BLANK_EN replaces leading zero digits with 4'hF as the result is loaded.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]          state;
    logic [WIDTH-1:0]    bin_sr;
    logic [4*DIGITS-1:0] scr;
    logic [CW-1:0]       cnt;

    logic [4*DIGITS-1:0] scr_adj;
    logic [4*DIGITS-1:0] scr_next;
    logic [WIDTH-1:0]    bin_next;
    logic                last_shift;

    // Result shaping applied once, when the finished scratch value is copied to bcd_out.
    function automatic logic [4*DIGITS-1:0] format_bcd(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
`ifdef BCD_LEADING_BLANK_EN
        logic leading;
        r       = v;
        leading = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (v[4*i +: 4] != 4'd0) begin
                leading = 1'b0;
            end
            if (leading) begin
                r[4*i +: 4] = 4'hF;
            end
        end
`else
        r = v;
`endif
        return r;
    endfunction

    // Add-3 correction on every digit that would overflow past 9 after the doubling shift.
    always_comb begin
        scr_adj = scr;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr[4*i +: 4] >= 4'd5) begin
                scr_adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
            end
        end
    end

    assign scr_next   = {scr_adj[4*DIGITS-2:0], bin_sr[WIDTH-1]};
    assign bin_next   = bin_sr << 1;
    assign last_shift = (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bin_sr  <= '0;
            scr     <= '0;
            cnt     <= '0;
            bcd_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bin_sr <= bin_in;
                        scr    <= '0;
                        cnt    <= CW'(WIDTH);
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    scr    <= scr_next;
                    bin_sr <= bin_next;
                    cnt    <= cnt - CW'(1);
                    // Loading on the final shift makes bcd_out valid in the same cycle done is high.
                    if (last_shift) begin
                        bcd_out <= format_bcd(scr_next);
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (WIDTH=10, DIGITS=4).
// Expected results follow BCD_LEADING_BLANK_EN when the macro is defined for the build.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;

    int tests_run;
    int tests_failed;

    typedef struct {
        string       name;
        logic [9:0]  bin;
        logic [15:0] plain;
        logic [15:0] blank;
    } vec_t;

    vec_t vecs[6];

    bin_to_bcd_seq #(.WIDTH(10), .DIGITS(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pick(input logic [15:0] plain, input logic [15:0] blank);
`ifdef BCD_LEADING_BLANK_EN
        return blank;
`else
        return plain;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One full conversion: start pulse, bounded wait for done, latency/busy/result/pulse-width checks.
    task automatic applyStimulus(input string name, input logic [9:0] val, input logic [15:0] expected);
        int lat;
        int busy_cnt;
        @(negedge clk);
        bin_in = val;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bin_in = ~val;
        lat      = -1;
        busy_cnt = 0;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (busy) busy_cnt++;
            if (done) lat = i;
        end
        checkOutput({name, " latency"}, lat, 10);
        checkOutput({name, " busy cycles"}, busy_cnt, 10);
        checkOutput({name, " bcd_out"}, {16'd0, bcd_out}, {16'd0, expected});
        @(posedge clk);
        #1;
        checkOutput({name, " done width"}, {31'd0, done}, 32'd0);
        checkOutput({name, " bcd_out hold"}, {16'd0, bcd_out}, {16'd0, expected});
    endtask

    initial begin
        int lat;
        int extra;
        int prev;
        int pulses;

        tests_run    = 0;
        tests_failed = 0;

        vecs[0] = '{name: "v1023", bin: 10'd1023, plain: 16'h1023, blank: 16'h1023};
        vecs[1] = '{name: "v0",    bin: 10'd0,    plain: 16'h0000, blank: 16'hFFF0};
        vecs[2] = '{name: "v255",  bin: 10'd255,  plain: 16'h0255, blank: 16'hF255};
        vecs[3] = '{name: "v100",  bin: 10'd100,  plain: 16'h0100, blank: 16'hF100};
        vecs[4] = '{name: "v9",    bin: 10'd9,    plain: 16'h0009, blank: 16'hFFF9};
        vecs[5] = '{name: "v640",  bin: 10'd640,  plain: 16'h0640, blank: 16'hF640};

        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        #3;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset bcd_out", {16'd0, bcd_out}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 6; k++) begin
            applyStimulus(vecs[k].name, vecs[k].bin, pick(vecs[k].plain, vecs[k].blank));
        end

        // start re-pulsed during SHIFT and during DONE must be ignored
        @(negedge clk);
        bin_in = 10'd7;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (i == 3) begin
                start  = 1'b1;
                bin_in = 10'd999;
            end else if (i == 4) begin
                start = 1'b0;
            end
            if (done) lat = i;
        end
        checkOutput("ignore latency", lat, 10);
        checkOutput("ignore bcd_out", {16'd0, bcd_out}, {16'd0, pick(16'h0007, 16'hFFF7)});
        start  = 1'b1;
        bin_in = 10'd999;
        @(posedge clk);
        #1;
        start = 1'b0;
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) extra++;
            @(posedge clk);
            #1;
        end
        checkOutput("ignore extra done", extra, 0);
        checkOutput("ignore bcd_out hold", {16'd0, bcd_out}, {16'd0, pick(16'h0007, 16'hFFF7)});
        applyStimulus("v999", 10'd999, pick(16'h0999, 16'hF999));

        // start held high: back-to-back conversions every WIDTH+2 cycles
        @(negedge clk);
        bin_in = 10'd42;
        start  = 1'b1;
        prev   = -1;
        pulses = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                checkOutput("held bcd_out", {16'd0, bcd_out}, {16'd0, pick(16'h0042, 16'hFF42)});
                if (prev >= 0) checkOutput("held spacing", c - prev, 12);
                prev = c;
            end
        end
        start = 1'b0;
        checkOutput("held pulse count", pulses, 3);
        repeat (15) @(posedge clk);

        // asynchronous reset five cycles into a conversion of 512
        @(negedge clk);
        bin_in = 10'd512;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort done", {31'd0, done}, 32'd0);
        checkOutput("abort bcd_out", {16'd0, bcd_out}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        checkOutput("abort no done", extra, 0);
        checkOutput("abort bcd_out idle", {16'd0, bcd_out}, 32'd0);
        applyStimulus("v512", 10'd512, pick(16'h0512, 16'hF512));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
